// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the funct3 access-size encodings, the sequencer state enum, the
// default request timeout and the legality/alignment helpers used by the
// top-level sequencer.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // Stores only exist in the signed encodings; loads add BU/HU.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Size is carried in funct3[1:0]: 01 halfword, 10 word.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU and data memory.
//   dmem_req/dmem_we/dmem_addr/dmem_be/dmem_wdata : LSU -> memory
//   dmem_ack/dmem_rdata                           : memory -> LSU
interface mem_stage_lsu_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU (purely combinational).
//   funct3_i : access size/sign
//   off_i    : byte offset within the word (addr[1:0])
//   wdata_i  : raw store data          -> wdata_o : lane-replicated store data
//   rdata_i  : raw read word           -> load_o  : extended load value
//   be_o     : byte enables for the access
import mem_pkg::*;

module lsu_align (
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata_i[7:0];
      case (off_i)
         2'd0:    lane_b = rdata_i[7:0];
         2'd1:    lane_b = rdata_i[15:8];
         2'd2:    lane_b = rdata_i[23:16];
         default: lane_b = rdata_i[31:24];
      endcase
      lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   always_comb begin
      load_o = rdata_i;
      case (funct3_i)
         F3_B:    load_o = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_o = {24'd0, lane_b};
         F3_H:    load_o = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_o = {16'd0, lane_h};
         default: load_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Turns an EX/MEM load or store into a
// request/ack transaction on the data-memory bus, stalls the pipeline
// while it is outstanding, and returns the extended load result.
//   clk, reset            : clock, synchronous active-low reset
//   memRead/memWrite_EX_MEM, funct3_EX_MEM, aluResult_EX_MEM,
//   writeData_EX_MEM      : access request from EX/MEM
//   data                  : registered load result to MEM/WB
//   stall                 : combinational pipeline freeze
//   memFault              : registered one-cycle fault pulse
//   dmem                  : data-memory bus (master side)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access outstanding; legal access launches a request
// REQ     | request on the bus, waiting for ack or timeout
// DONE    | one-cycle completion; pipeline released, back to IDLE
import mem_pkg::*;

module mem_stage_lsu #(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            memRead_EX_MEM,
   input  logic            memWrite_EX_MEM,
   input  logic [2:0]      funct3_EX_MEM,
   input  logic [31:0]     aluResult_EX_MEM,
   input  logic [31:0]     writeData_EX_MEM,
   output logic [31:0]     data,
   output logic            stall,
   output logic            memFault,
   mem_stage_lsu_if.master dmem
);

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   lsu_state_e  state_q;
   logic [3:0]  cnt_q;
   logic [31:0] data_q;
   logic        fault_q;
   logic        req_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        any_req;
   logic        access;
   logic        legal;
   logic        aligned;
   logic        go;
   logic        bad;

   logic [2:0]  al_f3;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_load;

   assign any_req = memRead_EX_MEM | memWrite_EX_MEM;
   assign access  = memRead_EX_MEM ^ memWrite_EX_MEM;
   assign legal   = ~(memRead_EX_MEM & memWrite_EX_MEM) &
                    f3_legal(memWrite_EX_MEM, funct3_EX_MEM);
   assign aligned = ~misaligned(funct3_EX_MEM[1:0], aluResult_EX_MEM[1:0]);
   assign go      = access & legal & aligned;
   assign bad     = any_req & ~(legal & aligned);

   assign stall = ((state_q == ST_IDLE) & go) | (state_q == ST_REQ);

   // Launch uses the live EX/MEM fields; the load return uses the latched ones.
   assign al_f3  = (state_q == ST_IDLE) ? funct3_EX_MEM : f3_q;
   assign al_off = (state_q == ST_IDLE) ? aluResult_EX_MEM[1:0] : off_q;

   lsu_align u_align (
      .funct3_i (al_f3),
      .off_i    (al_off),
      .wdata_i  (writeData_EX_MEM),
      .rdata_i  (dmem.dmem_rdata),
      .be_o     (al_be),
      .wdata_o  (al_wdata),
      .load_o   (al_load)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         data_q  <= 32'd0;
         fault_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
      end else begin
         fault_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (go) begin
                  state_q <= ST_REQ;
                  cnt_q   <= 4'd0;
                  req_q   <= 1'b1;
                  we_q    <= memWrite_EX_MEM;
                  addr_q  <= {aluResult_EX_MEM[31:2], 2'b00};
                  be_q    <= al_be;
                  wdata_q <= memWrite_EX_MEM ? al_wdata : 32'd0;
                  f3_q    <= funct3_EX_MEM;
                  off_q   <= aluResult_EX_MEM[1:0];
               end else if (bad) begin
                  fault_q <= 1'b1;
               end
            end
            ST_REQ: begin
               if (dmem.dmem_ack) begin
                  state_q <= ST_DONE;
                  req_q   <= 1'b0;
                  if (!we_q)
                     data_q <= al_load;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_DONE;
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
                  data_q  <= 32'd0;
               end else if (cnt_q != 4'hF) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data            = data_q;
   assign memFault        = fault_q;
   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
import mem_pkg::*;

module tb_mem_stage_lsu;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead_EX_MEM;
   logic        memWrite_EX_MEM;
   logic [2:0]  funct3_EX_MEM;
   logic [31:0] aluResult_EX_MEM;
   logic [31:0] writeData_EX_MEM;
   logic [31:0] data;
   logic        stall;
   logic        memFault;

   mem_stage_lsu_if dmem_bus ();

   mem_stage_lsu #(.TIMEOUT(TMO)) dut (
      .clk              (clk),
      .reset            (reset),
      .memRead_EX_MEM   (memRead_EX_MEM),
      .memWrite_EX_MEM  (memWrite_EX_MEM),
      .funct3_EX_MEM    (funct3_EX_MEM),
      .aluResult_EX_MEM (aluResult_EX_MEM),
      .writeData_EX_MEM (writeData_EX_MEM),
      .data             (data),
      .stall            (stall),
      .memFault         (memFault),
      .dmem             (dmem_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        fault_done;
      logic        fault_path;
      int          stalls;
      int          reqs;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_data = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model of one access, written from the access rules directly.
   function automatic exp_t model(input string tag, input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rword,
                                  input int ack_after);
      exp_t e;
      logic ok_f3, mis, go;
      logic [31:0] lane;
      e.tag = tag;
      if (wr) ok_f3 = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
      else    ok_f3 = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                       f3 == 3'b100 || f3 == 3'b101);
      mis = ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
            (f3 == 3'b010 && addr[1:0] != 2'b00);
      go  = (rd != wr) && ok_f3 && !mis;
      e.fault_path = (rd || wr) && !go;
      e.fault_done = go && (ack_after >= TMO);
      e.reqs   = go ? ((ack_after < TMO) ? ack_after + 1 : TMO) : 0;
      e.stalls = go ? e.reqs + 1 : 0;
      e.we     = wr;
      e.addr   = {addr[31:2], 2'b00};
      e.be     = 4'd0;
      e.wdata  = 32'd0;
      if (wr) begin
         case (f3)
            3'b000: begin
               e.be = 4'b0001 << addr[1:0];
               e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            end
            3'b001: begin
               e.be = 4'b0011 << (2 * addr[1]);
               e.wdata = {wd[15:0], wd[15:0]};
            end
            default: begin
               e.be = 4'b1111;
               e.wdata = wd;
            end
         endcase
      end
      e.data = model_data;
      if (go && ack_after >= TMO) e.data = 32'd0;
      else if (go && rd) begin
         case (f3)
            3'b000: begin lane = rword >> (8 * addr[1:0]); e.data = {{24{lane[7]}}, lane[7:0]}; end
            3'b100: begin lane = rword >> (8 * addr[1:0]); e.data = {24'd0, lane[7:0]}; end
            3'b001: begin lane = rword >> (16 * addr[1]); e.data = {{16{lane[15]}}, lane[15:0]}; end
            3'b101: begin lane = rword >> (16 * addr[1]); e.data = {16'd0, lane[15:0]}; end
            default: e.data = rword;
         endcase
      end
      return e;
   endfunction

   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rword,
                             input int ack_after);
      exp_t e;
      int   stall_n = 0;
      int   req_n = 0;
      bit   done = 0;
      sb_q.push_back(model(tag, rd, wr, f3, addr, wd, rword, ack_after));
      @(negedge clk);
      memRead_EX_MEM   = rd;
      memWrite_EX_MEM  = wr;
      funct3_EX_MEM    = f3;
      aluResult_EX_MEM = addr;
      writeData_EX_MEM = wd;
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = 32'd0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         if (dmem_bus.dmem_req) begin
            if (req_n == 0) begin
               e = sb_q[0];
               chk({tag, ".we"},   {31'd0, dmem_bus.dmem_we}, {31'd0, e.we});
               chk({tag, ".addr"}, dmem_bus.dmem_addr, e.addr);
               if (e.we) begin
                  chk({tag, ".be"},    {28'd0, dmem_bus.dmem_be}, {28'd0, e.be});
                  chk({tag, ".wdata"}, dmem_bus.dmem_wdata, e.wdata);
               end
            end
            dmem_bus.dmem_ack   = (req_n == ack_after);
            dmem_bus.dmem_rdata = (req_n == ack_after) ? rword : 32'hA5A5_A5A5;
            req_n++;
         end else begin
            dmem_bus.dmem_ack = 1'b0;
         end
         if (stall) stall_n++;
         else done = 1;
         if (!done) @(negedge clk);
      end
      e = sb_q.pop_front();
      chk({tag, ".finished"}, {31'd0, done}, 32'd1);
      chk({tag, ".stalls"},   stall_n, e.stalls);
      chk({tag, ".reqs"},     req_n, e.reqs);
      chk({tag, ".data"},     data, e.data);
      chk({tag, ".fault_done"}, {31'd0, memFault}, {31'd0, e.fault_done});
      @(negedge clk);
      memRead_EX_MEM  = 1'b0;
      memWrite_EX_MEM = 1'b0;
      dmem_bus.dmem_ack = 1'b0;
      #1;
      chk({tag, ".fault_next"}, {31'd0, memFault}, {31'd0, e.fault_path});
      chk({tag, ".data_hold"},  data, e.data);
      model_data = e.data;
   endtask

   initial begin
      reset = 1'b0;
      memRead_EX_MEM = 1'b0;
      memWrite_EX_MEM = 1'b0;
      funct3_EX_MEM = 3'd0;
      aluResult_EX_MEM = 32'd0;
      writeData_EX_MEM = 32'd0;
      dmem_bus.dmem_ack = 1'b0;
      dmem_bus.dmem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst.data",  data, 32'd0);
      chk("rst.fault", {31'd0, memFault}, 32'd0);
      chk("rst.req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
      chk("rst.we",    {31'd0, dmem_bus.dmem_we}, 32'd0);
      chk("rst.addr",  dmem_bus.dmem_addr, 32'd0);
      chk("rst.be",    {28'd0, dmem_bus.dmem_be}, 32'd0);
      chk("rst.wdata", dmem_bus.dmem_wdata, 32'd0);
      chk("rst.stall", {31'd0, stall}, 32'd0);

      run_access("lb",      1, 0, F3_B,  32'h0000_0103, 32'd0,         32'h80FF_0000, 0);
      run_access("sh",      0, 1, F3_H,  32'h0000_0202, 32'h0000_BEEF, 32'd0,         0);
      run_access("lw_mis",  1, 0, F3_W,  32'h0000_0101, 32'd0,         32'd0,         0);
      run_access("lhu_tmo", 1, 0, F3_HU, 32'h0000_0100, 32'd0,         32'h1234_5678, 99);
      run_access("lh",      1, 0, F3_H,  32'h0000_0102, 32'd0,         32'h8001_1234, 2);
      run_access("lbu",     1, 0, F3_BU, 32'h0000_0101, 32'd0,         32'h0000_AB00, 1);
      run_access("sb",      0, 1, F3_B,  32'h0000_0003, 32'h1234_565A, 32'd0,         0);
      run_access("sw",      0, 1, F3_W,  32'h0000_0010, 32'hCAFE_F00D, 32'd0,         3);
      run_access("both",    1, 1, F3_W,  32'h0000_0020, 32'd0,         32'd0,         0);
      run_access("sbu_ill", 0, 1, F3_BU, 32'h0000_0020, 32'h0000_0011, 32'd0,         0);
      run_access("sh_mis",  0, 1, F3_H,  32'h0000_0021, 32'h0000_0011, 32'd0,         0);
      run_access("lw_last", 1, 0, F3_W,  32'h0000_0200, 32'd0,         32'hDEAD_BEEF, TMO - 1);

      // Stray ack while idle must not touch data.
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b1;
      dmem_bus.dmem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0;
      #1;
      chk("stray_ack.data",  data, model_data);
      chk("stray_ack.fault", {31'd0, memFault}, 32'd0);

      // Reset asserted mid-request, ack arriving two cycles later.
      @(negedge clk);
      memRead_EX_MEM = 1'b1;
      funct3_EX_MEM = F3_W;
      aluResult_EX_MEM = 32'h0000_0300;
      @(negedge clk);
      #1;
      chk("rstreq.req_on", {31'd0, dmem_bus.dmem_req}, 32'd1);
      reset = 1'b0;
      memRead_EX_MEM = 1'b0;
      @(negedge clk);
      #1;
      chk("rstreq.req_off", {31'd0, dmem_bus.dmem_req}, 32'd0);
      chk("rstreq.fault",   {31'd0, memFault}, 32'd0);
      chk("rstreq.data",    data, 32'd0);
      chk("rstreq.stall",   {31'd0, stall}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b1;
      dmem_bus.dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0;
      #1;
      chk("late_ack.data",  data, 32'd0);
      chk("late_ack.fault", {31'd0, memFault}, 32'd0);
      chk("late_ack.req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
      model_data = 32'd0;

      run_access("lb_after", 1, 0, F3_B, 32'h0000_0040, 32'd0, 32'h0000_007F, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
